// File: rtl/qr_feeder_pkg.sv
// Shared constants and sender state encoding for the QR engine input feeder.
package qr_feeder_pkg;

   localparam int unsigned DATA_W      = 48;   // one H/y word
   localparam int unsigned GROUP_WORDS = 200;  // 10 RE x 20 words per group
   localparam int unsigned CNT_W       = 8;    // word counter width

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } send_state_t;

endpackage

// File: rtl/qr_feeder_bank.sv
// One ping-pong bank: single write port, single registered read port.
// The read register returns zero on cycles without a read so the two banks'
// outputs can simply be OR-combined by the parent.
//   i_clk, i_rst     : clock, async active-high reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request, data appears on rd_data next cycle
//   rd_data          : registered read data (zero when no read last cycle)
module qr_feeder_bank
   import qr_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 200
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [CNT_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage array, intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
      else            rd_data <= '0;
   end

endmodule

// File: rtl/qr_feeder.sv
// Ping-pong group buffer in front of the QR engine. Upstream words fill one
// bank while the other bank is streamed to the engine as a gap-free burst of
// GROUP_WORDS words; after a burst the sender waits for the engine's
// last-result indication before starting the next group.
//   i_clk, i_rst          : clock, async active-high reset
//   i_in_vld, i_in_data   : upstream word, accepted when o_in_rdy is high
//   o_in_rdy              : write bank has room
//   o_trig, o_data        : word stream toward the engine (o_data 0 when idle)
//   i_last_data           : engine finished the current group
//   o_wait                : burst sent, waiting for i_last_data
module qr_feeder #(
   parameter int unsigned DATA_W      = qr_feeder_pkg::DATA_W,
   parameter int unsigned GROUP_WORDS = qr_feeder_pkg::GROUP_WORDS
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_vld,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_rdy,
   output logic              o_trig,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_last_data,
   output logic              o_wait
);

   import qr_feeder_pkg::CNT_W;
   import qr_feeder_pkg::send_state_t;
   import qr_feeder_pkg::ST_IDLE;
   import qr_feeder_pkg::ST_SEND;
   import qr_feeder_pkg::ST_WAIT;

   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(GROUP_WORDS - 1);

   send_state_t      state_q, state_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [1:0]       full_q, full_d;
   logic             trig_d, wait_d, in_rdy_d;
   logic             accept, rd_en;
   logic [DATA_W-1:0] rd_data0, rd_data1;

   // Next-state logic for writer pointers, full flags and sender FSM.
   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      full_d    = full_q;
      rd_en     = 1'b0;
      accept    = i_in_vld & o_in_rdy;

      if (accept) begin
         if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
         end
      end

      // Reader only clears a full bank, writer only sets a non-full one,
      // so same-edge set and clear always target different banks.
      case (state_q)
         ST_IDLE: begin
            rd_cnt_d = '0;
            if (full_q[rd_bank_q]) state_d = ST_SEND;
         end
         ST_SEND: begin
            rd_en = 1'b1;
            if (rd_cnt_q == LAST_ADDR) begin
               rd_cnt_d          = '0;
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = ~rd_bank_q;
               state_d           = ST_WAIT;
            end else begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (i_last_data) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // o_trig tracks the read-port latency; o_wait rises once the last
      // word has left, i.e. from the second WAIT cycle onward.
      trig_d   = rd_en;
      wait_d   = (state_q == ST_WAIT) && (state_d == ST_WAIT);
      in_rdy_d = ~full_d[wr_bank_d];
   end

   // State registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         full_q    <= '0;
         o_trig    <= 1'b0;
         o_wait    <= 1'b0;
         o_in_rdy  <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         full_q    <= full_d;
         o_trig    <= trig_d;
         o_wait    <= wait_d;
         o_in_rdy  <= in_rdy_d;
      end
   end

   qr_feeder_bank #(.WIDTH(DATA_W), .DEPTH(GROUP_WORDS)) u_bank0 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (accept & ~wr_bank_q),
      .wr_addr (wr_cnt_q),
      .wr_data (i_in_data),
      .rd_en   (rd_en & ~rd_bank_q),
      .rd_addr (rd_cnt_q),
      .rd_data (rd_data0)
   );

   qr_feeder_bank #(.WIDTH(DATA_W), .DEPTH(GROUP_WORDS)) u_bank1 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .wr_en   (accept & wr_bank_q),
      .wr_addr (wr_cnt_q),
      .wr_data (i_in_data),
      .rd_en   (rd_en & rd_bank_q),
      .rd_addr (rd_cnt_q),
      .rd_data (rd_data1)
   );

   // Idle bank read registers hold zero, so OR selects the active bank.
   assign o_data = rd_data0 | rd_data1;

endmodule

// File: tb/tb_qr_feeder.sv
// Self-checking bench for qr_feeder: words written are queued in group order
// and every burst seen on o_trig/o_data is compared against that queue.
module tb_qr_feeder;

   localparam int unsigned DW = 48;
   localparam int unsigned GW = 200;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_in_vld;
   logic [DW-1:0] i_in_data;
   logic          o_in_rdy;
   logic          o_trig;
   logic [DW-1:0] o_data;
   logic          i_last_data;
   logic          o_wait;

   qr_feeder #(.DATA_W(DW), .GROUP_WORDS(GW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_in_vld    (i_in_vld),
      .i_in_data   (i_in_data),
      .o_in_rdy    (o_in_rdy),
      .o_trig      (o_trig),
      .o_data      (o_data),
      .i_last_data (i_last_data),
      .o_wait      (o_wait)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: completed groups in completion order, plus the group being filled.
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] part_q[$];

   // Observed stream.
   logic [DW-1:0] obs_q[$];
   int            burst_q[$];
   int            run_len = 0;
   int            trig_cycles = 0;
   int            zero_viol = 0;

   always @(negedge i_clk) begin
      if (i_rst) begin
         run_len = 0;
      end else if (o_trig) begin
         obs_q.push_back(o_data);
         run_len++;
         trig_cycles++;
      end else begin
         if (run_len > 0) begin
            burst_q.push_back(run_len);
            run_len = 0;
         end
         if (o_data !== '0) zero_viol++;
      end
   end

   function automatic logic [DW-1:0] rand_word();
      return DW'({$urandom(), $urandom()});
   endfunction

   // Drive one word until accepted; model records it.
   task automatic send_word(input logic [DW-1:0] w, output int stalls);
      stalls = 0;
      @(negedge i_clk);
      i_in_vld  = 1'b1;
      i_in_data = w;
      while (o_in_rdy !== 1'b1 && stalls < 1000) begin
         stalls++;
         @(negedge i_clk);
      end
      part_q.push_back(w);
      if (part_q.size() == GW) begin
         foreach (part_q[k]) exp_q.push_back(part_q[k]);
         part_q.delete();
      end
   endtask

   task automatic idle_input();
      @(negedge i_clk);
      i_in_vld = 1'b0;
   endtask

   task automatic wait_burst(input int nb, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge i_clk);
         #1;
         if (burst_q.size() > nb) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Pops one group from observed and expected streams, counting disagreements.
   task automatic drain_burst(output int bad, output int first_k,
                              output logic [DW-1:0] g, output logic [DW-1:0] w);
      logic [DW-1:0] gg, ww;
      bad = 0; first_k = -1; g = '0; w = '0;
      for (int k = 0; k < int'(GW); k++) begin
         if (obs_q.size() == 0 || exp_q.size() == 0) begin
            bad++;
            if (first_k < 0) first_k = k;
         end else begin
            gg = obs_q.pop_front();
            ww = exp_q.pop_front();
            if (gg !== ww) begin
               bad++;
               if (first_k < 0) begin first_k = k; g = gg; w = ww; end
            end
         end
      end
   endtask

   task automatic pulse_last();
      @(negedge i_clk);
      i_last_data = 1'b1;
      @(negedge i_clk);
      i_last_data = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_in_vld = 1'b0; i_in_data = '0; i_last_data = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      checks++; if (o_trig !== 1'b0)  begin errors++; $display("FAIL reset_trig got %b want 0", o_trig); end
      checks++; if (o_data !== '0)    begin errors++; $display("FAIL reset_data got %h want 0", o_data); end
      checks++; if (o_wait !== 1'b0)  begin errors++; $display("FAIL reset_wait got %b want 0", o_wait); end
      checks++; if (o_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", o_in_rdy); end
   endtask

   task automatic test_single_group();
      int st, stot, nb, bad, fk;
      bit ok;
      logic [DW-1:0] g, w;
      stot = 0; nb = burst_q.size();
      for (int i = 1; i <= int'(GW); i++) begin send_word(DW'(i), st); stot += st; end
      idle_input();
      checks++; if (stot != 0) begin errors++; $display("FAIL single_stalls got %0d want 0", stot); end
      wait_burst(nb, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_burst_timeout got none want 1 burst"); end
      else begin
         checks++; if (burst_q[nb] != int'(GW)) begin errors++; $display("FAIL single_len got %0d want %0d", burst_q[nb], GW); end
         checks++; if (obs_q.size() > 0 && obs_q[0] !== DW'(1)) begin errors++; $display("FAIL single_first got %h want 1", obs_q[0]); end
         drain_burst(bad, fk, g, w);
         checks++; if (bad != 0) begin errors++; $display("FAIL single_data bad %0d at %0d got %h want %h", bad, fk, g, w); end
      end
      @(negedge i_clk);
      checks++; if (o_wait !== 1'b1) begin errors++; $display("FAIL single_wait got %b want 1", o_wait); end
      pulse_last();
      @(negedge i_clk);
      checks++; if (o_wait !== 1'b0) begin errors++; $display("FAIL single_wait_clr got %b want 0", o_wait); end
   endtask

   task automatic test_stream_hold();
      int st, stot, nb, bad, fk;
      bit ok;
      logic [DW-1:0] g, w;
      stot = 0; nb = burst_q.size();
      for (int i = 0; i < 2 * int'(GW); i++) begin send_word(rand_word(), st); stot += st; end
      idle_input();
      checks++; if (stot != 0) begin errors++; $display("FAIL stream_stalls got %0d want 0", stot); end
      wait_burst(nb, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stream_burst_timeout got none want 1 burst"); end
      else begin
         checks++; if (burst_q[nb] != int'(GW)) begin errors++; $display("FAIL stream_len got %0d want %0d", burst_q[nb], GW); end
         drain_burst(bad, fk, g, w);
         checks++; if (bad != 0) begin errors++; $display("FAIL stream_data bad %0d at %0d got %h want %h", bad, fk, g, w); end
      end
      repeat (40) @(negedge i_clk);
      #1;
      checks++; if (burst_q.size() != nb + 1) begin errors++; $display("FAIL stream_no_second got %0d bursts want %0d", burst_q.size() - nb, 1); end
      checks++; if (o_wait !== 1'b1) begin errors++; $display("FAIL stream_wait got %b want 1", o_wait); end
      checks++; if (o_in_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy_free got %b want 1", o_in_rdy); end
      // Third group fills the freed bank; both banks then full.
      stot = 0;
      for (int i = 0; i < int'(GW); i++) begin send_word(rand_word(), st); stot += st; end
      idle_input();
      checks++; if (stot != 0) begin errors++; $display("FAIL third_stalls got %0d want 0", stot); end
      checks++; if (o_in_rdy !== 1'b0) begin errors++; $display("FAIL both_full_rdy got %b want 0", o_in_rdy); end
   endtask

   task automatic test_last_data();
      int nb, lat, bad, fk;
      bit ok;
      logic [DW-1:0] g, w;
      for (int grp = 0; grp < 2; grp++) begin
         nb = burst_q.size();
         @(negedge i_clk);
         i_last_data = 1'b1;
         @(negedge i_clk);
         i_last_data = 1'b0;
         lat = 1;
         while (o_trig !== 1'b1 && lat < 20) begin @(negedge i_clk); lat++; end
         checks++; if (lat > 3) begin errors++; $display("FAIL last_latency grp %0d got %0d want <=3", grp, lat); end
         // Pulse in mid-burst must be ignored.
         repeat (50) @(negedge i_clk);
         i_last_data = 1'b1;
         @(negedge i_clk);
         i_last_data = 1'b0;
         wait_burst(nb, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL last_burst_timeout grp %0d got none want 1 burst", grp); end
         else begin
            checks++; if (burst_q[nb] != int'(GW)) begin errors++; $display("FAIL last_len grp %0d got %0d want %0d", grp, burst_q[nb], GW); end
            drain_burst(bad, fk, g, w);
            checks++; if (bad != 0) begin errors++; $display("FAIL last_data grp %0d bad %0d at %0d got %h want %h", grp, bad, fk, g, w); end
         end
         @(negedge i_clk);
         checks++; if (o_wait !== 1'b1) begin errors++; $display("FAIL last_wait grp %0d got %b want 1", grp, o_wait); end
         checks++; if (o_in_rdy !== 1'b1) begin errors++; $display("FAIL last_rdy_free grp %0d got %b want 1", grp, o_in_rdy); end
      end
      pulse_last();
   endtask

   task automatic test_toggle_vld();
      int st, nb, tc, bad, fk;
      bit ok;
      logic [DW-1:0] g, w;
      nb = burst_q.size(); tc = trig_cycles;
      for (int i = 0; i < int'(GW); i++) begin
         send_word(rand_word(), st);
         idle_input();
      end
      #1;
      checks++; if (trig_cycles != tc) begin errors++; $display("FAIL toggle_early got %0d trig cycles want 0", trig_cycles - tc); end
      wait_burst(nb, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL toggle_burst_timeout got none want 1 burst"); end
      else begin
         checks++; if (burst_q[nb] != int'(GW)) begin errors++; $display("FAIL toggle_len got %0d want %0d", burst_q[nb], GW); end
         drain_burst(bad, fk, g, w);
         checks++; if (bad != 0) begin errors++; $display("FAIL toggle_data bad %0d at %0d got %h want %h", bad, fk, g, w); end
      end
      pulse_last();
   endtask

   task automatic test_reset_mid();
      int st, nb, tc, cnt, bad, fk;
      bit ok;
      logic [DW-1:0] g, w, first;
      for (int i = 0; i < int'(GW); i++) send_word(rand_word(), st);
      idle_input();
      cnt = 0;
      for (int c = 0; c < 1000 && cnt < 100; c++) begin
         @(negedge i_clk);
         if (o_trig === 1'b1) cnt++;
      end
      checks++; if (cnt != 100) begin errors++; $display("FAIL rst_reach_send got %0d want 100", cnt); end
      #1 i_rst = 1'b1;
      #1;
      checks++; if (o_trig !== 1'b0) begin errors++; $display("FAIL rst_async_trig got %b want 0", o_trig); end
      checks++; if (o_data !== '0)   begin errors++; $display("FAIL rst_async_data got %h want 0", o_data); end
      @(negedge i_clk);
      i_rst = 1'b0;
      exp_q.delete(); part_q.delete();
      @(negedge i_clk);
      #1;
      obs_q.delete();
      checks++; if (o_in_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b want 1", o_in_rdy); end
      checks++; if (o_wait !== 1'b0)   begin errors++; $display("FAIL rst_wait got %b want 0", o_wait); end
      // Partial group, then reset mid-fill.
      for (int i = 0; i < 120; i++) send_word(rand_word(), st);
      idle_input();
      #1 i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      exp_q.delete(); part_q.delete();
      nb = burst_q.size(); tc = trig_cycles;
      first = rand_word();
      send_word(first, st);
      for (int i = 1; i < int'(GW) - 1; i++) send_word(rand_word(), st);
      idle_input();
      repeat (10) @(negedge i_clk);
      #1;
      checks++; if (trig_cycles != tc) begin errors++; $display("FAIL rst_stale_burst got %0d trig cycles want 0", trig_cycles - tc); end
      send_word(rand_word(), st);
      idle_input();
      wait_burst(nb, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_burst_timeout got none want 1 burst"); end
      else begin
         checks++; if (burst_q[nb] != int'(GW)) begin errors++; $display("FAIL rst_len got %0d want %0d", burst_q[nb], GW); end
         checks++; if (obs_q.size() == 0 || obs_q[0] !== first) begin errors++; $display("FAIL rst_first got %h want %h", (obs_q.size() > 0) ? obs_q[0] : '0, first); end
         drain_burst(bad, fk, g, w);
         checks++; if (bad != 0) begin errors++; $display("FAIL rst_data bad %0d at %0d got %h want %h", bad, fk, g, w); end
      end
      pulse_last();
   endtask

   initial begin
      test_reset();
      test_single_group();
      test_stream_hold();
      test_last_data();
      test_toggle_vld();
      test_reset_mid();
      repeat (5) @(negedge i_clk);
      checks++; if (zero_viol != 0) begin errors++; $display("FAIL idle_data_zero got %0d nonzero cycles want 0", zero_viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/qr_feeder.md
QR_FEEDER -- requirements
Module: qr_feeder

Interface
REQ-001 Parameter DATA_W, 48, width of one H/y input word.
REQ-002 Parameter GROUP_WORDS, 200, words per 10-RE group (10 RE x 20 words).
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_in_vld  input  1  upstream word valid.
REQ-006 i_in_data  input  DATA_W  upstream H/y word.
REQ-007 o_in_rdy  output  1  feeder can accept a word this cycle.
REQ-008 o_trig  output  1  word valid toward QR engine (drives engine i_trig).
REQ-009 o_data  output  DATA_W  word toward QR engine (drives engine i_data).
REQ-010 i_last_data  input  1  engine's o_last_data: last result of the current group delivered.
REQ-011 o_wait  output  1  group sent, waiting for i_last_data.

Function
REQ-012 Storage SHALL be two banks (ping-pong), each GROUP_WORDS x DATA_W, with per-bank full flags, write bank pointer wr_bank, write counter wr_cnt, read bank pointer rd_bank, read counter rd_cnt.
REQ-013 o_in_rdy SHALL equal NOT full[wr_bank], from registered state only (no combinational path from i_in_vld).
REQ-014 Accept = i_in_vld AND o_in_rdy; accepted word written to bank wr_bank at address wr_cnt; wr_cnt increments.
REQ-015 On accept with wr_cnt = GROUP_WORDS-1: wr_cnt wraps to 0, full[wr_bank] set, wr_bank toggles, all in the same edge.
REQ-016 Sender FSM states: IDLE, SEND, WAIT.
REQ-017 IDLE -> SEND when full[rd_bank] = 1; rd_cnt = 0.
REQ-018 SEND: one word read per cycle; o_trig and o_data registered, one-cycle read latency; o_trig SHALL be high for exactly GROUP_WORDS consecutive cycles with word k of the bank on the k-th cycle, no gaps.
REQ-019 On reading address GROUP_WORDS-1: clear full[rd_bank], toggle rd_bank, go to WAIT.
REQ-020 WAIT: o_trig = 0, o_wait = 1; i_last_data = 1 sampled -> IDLE; next SEND may start the following cycle if the other bank is full.
REQ-021 i_last_data SHALL be ignored in IDLE and SEND.
REQ-022 o_data SHALL be 0 whenever o_trig = 0.
REQ-023 Same-edge full-set by writer and full-clear by reader on different banks SHALL both take effect; o_in_rdy reflects a freed bank one cycle after the clear.
REQ-024 Filling the other bank SHALL proceed during SEND and WAIT; upstream stalls only when both banks are full.
REQ-025 Group order SHALL be preserved: groups sent in the order completed.

Reset
REQ-026 On i_rst: FSM IDLE, wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0, full flags 0, o_trig = 0, o_data = 0, o_wait = 0, o_in_rdy = 1 after release; bank memory contents not reset.
REQ-027 Reset mid-fill or mid-SEND SHALL discard the partial group; no o_trig pulse after reset until a new complete group is written.

Structure
REQ-028 Shared package SHALL hold DATA_W, GROUP_WORDS, counter width (8 bits) and the sender state enumeration.
REQ-029 One sub-module qr_feeder_bank (single write port, single registered read port, GROUP_WORDS x DATA_W) SHALL be instantiated twice; FSM and pointers stay in qr_feeder.

Verification
REQ-030 Reset, then 200 words 0x000000000001..0x0000000000C8 back-to-back -> o_trig high 200 consecutive cycles, o_data 0x...01 through 0x...C8 in order, then o_wait = 1.
REQ-031 400 words streamed continuously, i_last_data held 0 -> second group fully buffered, o_in_rdy = 0 only after word 400 if sender still in WAIT; no second o_trig burst until i_last_data pulses.
REQ-032 i_last_data pulse in WAIT with second bank full -> IDLE, then SEND of group 2 starting within 2 cycles; pulse during SEND -> ignored, burst length still 200.
REQ-033 i_in_vld toggling every other cycle -> burst starts only after word 200 accepted and remains gap-free for 200 cycles.
REQ-034 i_rst asserted at SEND cycle 100 -> o_trig = 0 immediately (asynchronous), o_in_rdy = 1 after release, next burst only after 200 new words, first o_data = first new word.
REQ-035 Loop qr_feeder into QR_Engine for 10 groups of packet_1 -> engine outputs match golden R and y_hat for all 100 REs.
